// File: rtl/uart_cmd_parser_if.sv
// Handshake bundle between the UART receiver, the command parser and the SD command engine.
// master = the surrounding system (UART + SD engine); slave = the parser.
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  rx_ack, cmd_index, cmd_arg, cmd_valid, err_pulse, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output rx_ack, cmd_index, cmd_arg, cmd_valid, err_pulse, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Pulls bytes from the UART, assembles 7-byte host frames (sync, cmd, 4 arg bytes, xor checksum)
// into SD commands, and reports framing errors and inter-byte timeouts.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 500000,
  parameter int         TW        = 19
) (
  input logic              ex_clk,
  input logic              reset,
  uart_cmd_parser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ARG,
    S_CHK,
    S_OUT
  } state_t;

  typedef enum logic [1:0] {
    E_CHECKSUM = 2'd0,
    E_PREFIX   = 2'd1,
    E_TIMEOUT  = 2'd2
  } err_t;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic          ack_pending;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    chk;
  logic          take;
  logic          in_frame;
  logic          expired;

  // The UART clears rx_valid on its slower clock, so a byte stays visible for a few
  // cycles after we ack it; ack_pending blocks a second read until rx_valid drops.
  assign take     = bus.rx_valid & ~ack_pending & (state != S_OUT);
  assign in_frame = (state == S_CMD) || (state == S_ARG) || (state == S_CHK);
  assign expired  = in_frame && !take && (to_cnt == TO_LAST);

  // NOTE: every register here is assigned non-blocking so all updates see pre-edge values.
  always_ff @(posedge ex_clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      ack_pending   <= 1'b0;
      byte_cnt      <= '0;
      to_cnt        <= '0;
      chk           <= '0;
      bus.rx_ack    <= 1'b0;
      bus.cmd_index <= '0;
      bus.cmd_arg   <= '0;
      bus.cmd_valid <= 1'b0;
      bus.err_pulse <= 1'b0;
      bus.err_code  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.rx_ack    <= take;
      bus.err_pulse <= 1'b0;

      if (!bus.rx_valid)
        ack_pending <= 1'b0;
      else if (take)
        ack_pending <= 1'b1;

      if (in_frame && !take && !expired)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;

      if (expired) begin
        state         <= S_IDLE;
        bus.busy      <= 1'b0;
        bus.err_pulse <= 1'b1;
        bus.err_code  <= E_TIMEOUT;
      end else begin
        case (state)
          S_IDLE: begin
            if (take && bus.rx_data == SYNC_BYTE) begin
              state    <= S_CMD;
              bus.busy <= 1'b1;
            end
          end

          S_CMD: begin
            if (take) begin
              if (bus.rx_data[7:6] != 2'b01) begin
                state         <= S_IDLE;
                bus.busy      <= 1'b0;
                bus.err_pulse <= 1'b1;
                bus.err_code  <= E_PREFIX;
              end else begin
                bus.cmd_index <= bus.rx_data[5:0];
                chk           <= bus.rx_data;
                byte_cnt      <= 2'd3;
                state         <= S_ARG;
              end
            end
          end

          S_ARG: begin
            if (take) begin
              bus.cmd_arg <= {bus.cmd_arg[23:0], bus.rx_data};
              chk         <= chk ^ bus.rx_data;
              if (byte_cnt == 2'd0)
                state <= S_CHK;
              else
                byte_cnt <= byte_cnt - 2'd1;
            end
          end

          S_CHK: begin
            if (take) begin
              if (bus.rx_data == chk) begin
                bus.cmd_valid <= 1'b1;
                state         <= S_OUT;
              end else begin
                state         <= S_IDLE;
                bus.busy      <= 1'b0;
                bus.err_pulse <= 1'b1;
                bus.err_code  <= E_CHECKSUM;
              end
            end
          end

          S_OUT: begin
            if (bus.cmd_valid && bus.cmd_ready) begin
              bus.cmd_valid <= 1'b0;
              state         <= S_IDLE;
              bus.busy      <= 1'b0;
            end
          end

          default: begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and upstream of the SD command engine.
- Pulls received bytes from the UART using a valid/ack handshake.
- Assembles each 7-byte host frame into a validated SD command (6-bit index plus 32-bit argument).
- Presents the command on a valid/ready interface and reports framing errors.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 500000, max ex_clk cycles allowed between consecutive bytes inside a frame (10 ms at 50 MHz).
- TW, 19, width of the inter-byte timeout counter; must hold TIMEOUT.

Ports:
- ex_clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte from the UART; stable while rx_valid=1.
- rx_valid  input  1  level: the UART holds an unread byte (rx-contains flag).
- rx_ack  output  1  one-cycle pulse: byte consumed; drives the UART rx-clear control bit.
- cmd_index  output  6  SD command index; stable while cmd_valid=1.
- cmd_arg  output  32  SD command argument, MSB first on the wire; stable while cmd_valid=1.
- cmd_valid  output  1  a validated command is pending.
- cmd_ready  input  1  the SD engine accepts the command.
- err_pulse  output  1  one-cycle pulse: frame dropped.
- err_code  output  2  cause of the last error: 0 checksum, 1 bad cmd prefix, 2 timeout, 3 reserved. Holds until the next error.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: rx_ack, cmd_valid, err_pulse, busy, cmd_index, cmd_arg, err_code.
  - Internal byte count, timeout count, checksum and ack_pending are all 0.
  - An in-flight frame is discarded.
- Byte take (shared by all receiving states):
  - take = rx_valid & ~ack_pending.
  - On take, register rx_data and pulse rx_ack for exactly 1 cycle, then set ack_pending.
  - ack_pending clears only on a cycle where rx_valid=0. The UART runs on a slower divided clock, so this prevents a byte being read twice.
  - No take happens in state OUT.
- Frame format, in order:
  1. SYNC_BYTE.
  2. CMD: bits[7:6] must be 2'b01; bits[5:0] are the index.
  3. ARG3, ARG2, ARG1, ARG0.
  4. CHK = XOR of CMD and ARG3..ARG0.
- States:
  - IDLE: on each take, compare the byte with SYNC_BYTE. On a match go to CMD; otherwise discard silently and stay in IDLE (no error).
  - CMD:
    - On take, if byte[7:6]!=2'b01: err_pulse, err_code=1, go to IDLE.
    - Otherwise: index <= byte[5:0], chk <= byte, byte count <= 3, go to ARG.
  - ARG:
    - On take: cmd_arg <= {cmd_arg[23:0], byte}, chk <= chk ^ byte.
    - Leave for CHK when byte count reaches 0; otherwise decrement.
    - Exactly 4 bytes are taken in ARG.
  - CHK:
    - On take, if byte==chk: cmd_valid <= 1 on the next cycle, go to OUT.
    - Otherwise: err_pulse, err_code=0, go to IDLE; cmd_arg/cmd_index contents are don't-care.
  - OUT:
    - cmd_valid=1; cmd_index and cmd_arg are held.
    - When cmd_valid & cmd_ready in a cycle: cmd_valid=0 next cycle, go to IDLE.
    - Incoming bytes wait in the UART (backpressure, no loss).
    - The timeout does not run in OUT.
- Timeout:
  - In CMD, ARG and CHK, the counter increments every cycle and resets to 0 on each take.
  - When the count reaches TIMEOUT-1 with no take: err_pulse, err_code=2, go to IDLE.
  - If a take and expiry fall in the same cycle, the take wins and there is no error.
  - The counter is held at 0 in IDLE and OUT.
- Timing:
  - Minimum latency from the CHK byte's take to cmd_valid is 1 cycle.
  - Back-to-back frames are fine: cmd_ready asserted in the same cycle cmd_valid rises returns to IDLE next cycle.
  - An SYNC_BYTE value appearing mid-frame is treated as data, not a resync.
- Reset mid-frame or mid-OUT: immediate return to reset values; the pending command is lost.

Test Plan:
- Valid frame A5,51,00,00,12,34,77 (CHK=51^00^00^12^34=77), cmd_ready=1 -> cmd_valid for 1 cycle with cmd_index=0x11, cmd_arg=0x00001234; exactly 7 rx_ack pulses; busy returns to 0.
- Bad checksum A5,40,00,00,00,00,41 -> err_pulse once, err_code=0, no cmd_valid, state IDLE; a following valid frame is accepted normally.
- Bad prefix A5,C0 -> err_pulse and err_code=1 after the 2nd byte; the remaining bytes 00..00 are discarded in IDLE with no further error.
- Garbage 00,FF,A4 then a valid frame -> no error; the command is decoded correctly.
- Send A5,40,12 then stall TIMEOUT cycles -> err_pulse with err_code=2 at exactly TIMEOUT cycles after the last take; with TIMEOUT-1 cycles of idle and then the byte arriving, no error.
- Backpressure: valid frame with cmd_ready=0 for 100 cycles while the UART holds the next byte (rx_valid=1) -> no rx_ack, cmd_index/cmd_arg stable. Then cmd_ready=1 -> handshake; the next byte is taken afterwards. Separately, assert reset during ARG -> all outputs 0 immediately.
